// File: rtl/rr_arb_pkg.sv
// Shared arbitration types and the round-robin pick function used by rr_arb_mux.
package rr_arb_pkg;

  localparam int unsigned MAX_CH    = 16;
  localparam int unsigned MAX_SEL_W = 4;

  typedef struct packed {
    logic                 any;
    logic [MAX_SEL_W-1:0] idx;
  } pick_t;

  // First valid index scanning ptr, ptr+1, ... modulo num_ch; any=0 when nothing is valid.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0]    valid,
                                    input logic [MAX_SEL_W-1:0] ptr,
                                    input int unsigned          num_ch);
    pick_t       res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= num_ch) idx = idx - num_ch;
      if ((k < num_ch) && !res.any && valid[idx[MAX_SEL_W-1:0]]) begin
        res.any = 1'b1;
        res.idx = idx[MAX_SEL_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Valid/ready bundle between the requesters, rr_arb_mux and the downstream port.
// In/out last-beat signals exist only when RR_ARB_MUX_LOCK_EN is defined.
interface rr_arb_mux_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [NUM_CH-1:0]       in_last;
  logic                    out_last;

  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_data, out_sel, out_last);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_data, out_sel, out_last);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_sel);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_sel);
`endif

endinterface

// File: rtl/rr_arb_pick.sv
// Combinational round-robin priority rotate: first valid channel at or after ptr.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any
);

  logic [MAX_CH-1:0]    w_valid_ext;
  logic [MAX_SEL_W-1:0] w_ptr_ext;
  pick_t                w_pick;

  // Widen to the package's fixed width and pick the winner.
  always_comb begin
    w_valid_ext               = '0;
    w_valid_ext[NUM_CH-1:0]   = valid;
    w_ptr_ext                 = '0;
    w_ptr_ext[SEL_W-1:0]      = ptr;
    w_pick                    = rr_pick(w_valid_ext, w_ptr_ext, NUM_CH);
    grant_idx                 = w_pick.idx[SEL_W-1:0];
    any                       = w_pick.any;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin N:1 valid/ready mux with a single registered output stage.
// Optional packet lock (grant held until in_last) with `define RR_ARB_MUX_LOCK_EN.
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 4
) (
  input  logic         clk,
  input  logic         reset,
  rr_arb_mux_if.slave  bus
);

  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_sel;
  logic [SEL_W-1:0]  r_ptr;

  logic [NUM_CH-1:0] w_arb_valid;
  logic [SEL_W-1:0]  w_grant;
  logic              w_any;
  logic              w_load;
  logic              w_xfer;
  logic [NUM_CH-1:0] w_in_ready;
  logic [WIDTH-1:0]  w_win_data;
  logic [SEL_W-1:0]  w_ptr_next;

`ifdef RR_ARB_MUX_LOCK_EN
  logic              r_lock;
  logic [SEL_W-1:0]  r_lock_ch;
  logic              r_out_last;
  logic              w_win_last;
`endif

  // Candidate set: all requesters, or only the locked channel mid-packet.
  always_comb begin
    w_arb_valid = bus.in_valid;
`ifdef RR_ARB_MUX_LOCK_EN
    if (r_lock) begin
      w_arb_valid            = '0;
      w_arb_valid[r_lock_ch] = bus.in_valid[r_lock_ch];
    end
`endif
  end

  rr_arb_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_pick (
    .valid     (w_arb_valid),
    .ptr       (r_ptr),
    .grant_idx (w_grant),
    .any       (w_any)
  );

  // Handshake decode: the winner is accepted whenever the output stage can load.
  always_comb begin
    w_load     = !r_out_valid || bus.out_ready;
    w_xfer     = w_any && w_load && !reset;
    w_in_ready = '0;
    if (w_xfer) w_in_ready[w_grant] = 1'b1;
    w_win_data = bus.in_data[32'(w_grant)*WIDTH +: WIDTH];
    w_ptr_next = (w_grant == SEL_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
    w_win_last = bus.in_last[w_grant];
`endif
  end

  // Output stage and priority pointer; ptr only moves on a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_win_data;
      r_out_sel   <= w_grant;
      r_ptr       <= w_ptr_next;
    end else if (w_load) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef RR_ARB_MUX_LOCK_EN
  // Packet lock: a non-last beat pins the grant to its channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock     <= 1'b0;
      r_lock_ch  <= '0;
      r_out_last <= 1'b0;
    end else if (w_xfer) begin
      r_lock     <= !w_win_last;
      r_lock_ch  <= w_grant;
      r_out_last <= w_win_last;
    end
  end

  assign bus.out_last = r_out_last;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel and a 3-channel instance on one clock.
module tb_rr_arb_mux;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  rr_arb_mux_if #(.WIDTH(32), .NUM_CH(4)) b4 ();
  rr_arb_mux_if #(.WIDTH(32), .NUM_CH(3)) b3 ();

  rr_arb_mux #(.WIDTH(32), .NUM_CH(4)) u_dut4 (.clk(clk), .reset(reset), .bus(b4));
  rr_arb_mux #(.WIDTH(32), .NUM_CH(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1;
    b4.in_valid = 4'b1111;
    b4.out_ready = 1'b1;
    b3.in_valid = 3'b000;
    b3.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) b4.in_data[i*32 +: 32] = 32'h1000 + i;
    for (int i = 0; i < 3; i++) b3.in_data[i*32 +: 32] = 32'h2000 + i;
`ifdef RR_ARB_MUX_LOCK_EN
    b4.in_last = 4'b1111;
    b3.in_last = 3'b111;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++; if (b4.out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %0b want 0", b4.out_valid); end
    vecs++; if (b4.out_sel !== 2'd0) begin errs++; $display("FAIL rst_sel: got %0d want 0", b4.out_sel); end
    vecs++; if (b4.out_data !== 32'h0) begin errs++; $display("FAIL rst_data: got %h want 0", b4.out_data); end
    vecs++; if (b4.in_ready !== 4'b0000) begin errs++; $display("FAIL rst_ready: got %b want 0000", b4.in_ready); end
`ifdef RR_ARB_MUX_LOCK_EN
    vecs++; if (b4.out_last !== 1'b0) begin errs++; $display("FAIL rst_last: got %0b want 0", b4.out_last); end
`endif
    reset = 1'b0;
    #1;
    vecs++; if (b4.in_ready !== 4'b0001) begin errs++; $display("FAIL rel_ready: got %b want 0001", b4.in_ready); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_rdy;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      vecs++; if (b4.out_valid !== 1'b1 || b4.out_sel !== 2'(k % 4))
        begin errs++; $display("FAIL cont_sel[%0d]: got v%0b s%0d want v1 s%0d", k, b4.out_valid, b4.out_sel, k % 4); end
      vecs++; if (b4.out_data !== 32'h1000 + 32'(k % 4))
        begin errs++; $display("FAIL cont_data[%0d]: got %h want %h", k, b4.out_data, 32'h1000 + 32'(k % 4)); end
      exp_rdy = 4'b0001 << ((k + 1) % 4);
      #1;
      vecs++; if (b4.in_ready !== exp_rdy)
        begin errs++; $display("FAIL cont_ready[%0d]: got %b want %b", k, b4.in_ready, exp_rdy); end
    end
  endtask

  task automatic test_backpressure();
    b4.out_ready = 1'b0;
    #1;
    vecs++; if (b4.in_ready !== 4'b0000) begin errs++; $display("FAIL bp_ready0: got %b want 0000", b4.in_ready); end
    repeat (3) begin
      @(negedge clk);
      vecs++; if (b4.out_valid !== 1'b1 || b4.out_sel !== 2'd2 || b4.out_data !== 32'h1002)
        begin errs++; $display("FAIL bp_hold: got v%0b s%0d d%h want v1 s2 d1002", b4.out_valid, b4.out_sel, b4.out_data); end
      vecs++; if (b4.in_ready !== 4'b0000) begin errs++; $display("FAIL bp_ready: got %b want 0000", b4.in_ready); end
    end
    b4.out_ready = 1'b1;
    #1;
    vecs++; if (b4.in_ready !== 4'b1000) begin errs++; $display("FAIL bp_release: got %b want 1000", b4.in_ready); end
    @(negedge clk);
    vecs++; if (b4.out_sel !== 2'd3 || b4.out_data !== 32'h1003)
      begin errs++; $display("FAIL bp_next: got s%0d d%h want s3 d1003", b4.out_sel, b4.out_data); end
    @(negedge clk);
    vecs++; if (b4.out_sel !== 2'd0 || b4.out_valid !== 1'b1)
      begin errs++; $display("FAIL bp_next2: got s%0d v%0b want s0 v1", b4.out_sel, b4.out_valid); end
  endtask

  task automatic test_sparse_idle();
    b4.in_valid = 4'b0100;
    #1;
    vecs++; if (b4.in_ready !== 4'b0100) begin errs++; $display("FAIL sp_ready1: got %b want 0100", b4.in_ready); end
    @(negedge clk);
    vecs++; if (b4.out_sel !== 2'd2 || b4.out_valid !== 1'b1)
      begin errs++; $display("FAIL sp_beat1: got s%0d v%0b want s2 v1", b4.out_sel, b4.out_valid); end
    #1;
    vecs++; if (b4.in_ready !== 4'b0100) begin errs++; $display("FAIL sp_wrap: got %b want 0100", b4.in_ready); end
    @(negedge clk);
    vecs++; if (b4.out_sel !== 2'd2 || b4.out_data !== 32'h1002 || b4.out_valid !== 1'b1)
      begin errs++; $display("FAIL sp_beat2: got s%0d d%h v%0b want s2 d1002 v1", b4.out_sel, b4.out_data, b4.out_valid); end
    b4.in_valid = 4'b0000;
    #1;
    vecs++; if (b4.in_ready !== 4'b0000) begin errs++; $display("FAIL sp_idle_ready: got %b want 0000", b4.in_ready); end
    repeat (5) begin
      @(negedge clk);
      vecs++; if (b4.out_valid !== 1'b0 || b4.out_sel !== 2'd2 || b4.out_data !== 32'h1002)
        begin errs++; $display("FAIL sp_idle: got v%0b s%0d d%h want v0 s2 d1002", b4.out_valid, b4.out_sel, b4.out_data); end
    end
    b4.in_valid = 4'b0101;
    #1;
    vecs++; if (b4.in_ready !== 4'b0001) begin errs++; $display("FAIL sp_ptr_kept: got %b want 0001", b4.in_ready); end
    @(negedge clk);
    vecs++; if (b4.out_sel !== 2'd0 || b4.out_data !== 32'h1000)
      begin errs++; $display("FAIL sp_beat3: got s%0d d%h want s0 d1000", b4.out_sel, b4.out_data); end
  endtask

  task automatic test_reset_mid();
    b4.in_valid = 4'b0010;
    #1;
    vecs++; if (b4.in_ready !== 4'b0010) begin errs++; $display("FAIL rm_ready: got %b want 0010", b4.in_ready); end
    @(negedge clk);
    vecs++; if (b4.out_sel !== 2'd1 || b4.out_valid !== 1'b1)
      begin errs++; $display("FAIL rm_beat: got s%0d v%0b want s1 v1", b4.out_sel, b4.out_valid); end
    b4.out_ready = 1'b0;
    b4.in_valid = 4'b1111;
    reset = 1'b1;
    #1;
    vecs++; if (b4.in_ready !== 4'b0000) begin errs++; $display("FAIL rm_rst_ready: got %b want 0000", b4.in_ready); end
    @(negedge clk);
    vecs++; if (b4.out_valid !== 1'b0 || b4.out_sel !== 2'd0 || b4.out_data !== 32'h0)
      begin errs++; $display("FAIL rm_cleared: got v%0b s%0d d%h want v0 s0 d0", b4.out_valid, b4.out_sel, b4.out_data); end
    reset = 1'b0;
    b4.out_ready = 1'b1;
    #1;
    vecs++; if (b4.in_ready !== 4'b0001) begin errs++; $display("FAIL rm_ptr0: got %b want 0001", b4.in_ready); end
    b4.in_valid = 4'b0000;
    @(negedge clk);
    vecs++; if (b4.out_valid !== 1'b0) begin errs++; $display("FAIL rm_idle: got %0b want 0", b4.out_valid); end
  endtask

  task automatic test_non_pow2();
    b3.in_valid = 3'b111;
    #1;
    vecs++; if (b3.in_ready !== 3'b001) begin errs++; $display("FAIL np_ready: got %b want 001", b3.in_ready); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vecs++; if (b3.out_valid !== 1'b1 || b3.out_sel !== 2'(k % 3) || b3.out_data !== 32'h2000 + 32'(k % 3))
        begin errs++; $display("FAIL np_seq[%0d]: got v%0b s%0d d%h want v1 s%0d", k, b3.out_valid, b3.out_sel, b3.out_data, k % 3); end
    end
    b3.in_valid = 3'b000;
  endtask

`ifdef RR_ARB_MUX_LOCK_EN
  task automatic test_lock();
    b4.in_valid = 4'b0001;
    b4.in_last = 4'b0001;
    #1;
    vecs++; if (b4.in_ready !== 4'b0001) begin errs++; $display("FAIL lk_pre: got %b want 0001", b4.in_ready); end
    @(negedge clk);
    b4.in_valid = 4'b0111;
    b4.in_last = 4'b0101;
    #1;
    vecs++; if (b4.in_ready !== 4'b0010) begin errs++; $display("FAIL lk_r1: got %b want 0010", b4.in_ready); end
    @(negedge clk);
    vecs++; if (b4.out_sel !== 2'd1 || b4.out_last !== 1'b0)
      begin errs++; $display("FAIL lk_b1: got s%0d l%0b want s1 l0", b4.out_sel, b4.out_last); end
    #1;
    vecs++; if (b4.in_ready !== 4'b0010) begin errs++; $display("FAIL lk_held: got %b want 0010", b4.in_ready); end
    @(negedge clk);
    vecs++; if (b4.out_sel !== 2'd1 || b4.out_last !== 1'b0)
      begin errs++; $display("FAIL lk_b2: got s%0d l%0b want s1 l0", b4.out_sel, b4.out_last); end
    b4.in_last = 4'b0111;
    @(negedge clk);
    vecs++; if (b4.out_sel !== 2'd1 || b4.out_last !== 1'b1)
      begin errs++; $display("FAIL lk_b3: got s%0d l%0b want s1 l1", b4.out_sel, b4.out_last); end
    #1;
    vecs++; if (b4.in_ready !== 4'b0100) begin errs++; $display("FAIL lk_unlock: got %b want 0100", b4.in_ready); end
    @(negedge clk);
    vecs++; if (b4.out_sel !== 2'd2) begin errs++; $display("FAIL lk_b4: got s%0d want s2", b4.out_sel); end
    @(negedge clk);
    vecs++; if (b4.out_sel !== 2'd0) begin errs++; $display("FAIL lk_b5: got s%0d want s0", b4.out_sel); end
    b4.in_valid = 4'b0000;
  endtask
`endif

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_contention();
    test_backpressure();
    test_sparse_idle();
    test_reset_mid();
    test_non_pow2();
`ifdef RR_ARB_MUX_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised successor to the combinational 4-way select.
- Selects one of NUM_CH valid/ready input channels by round-robin arbitration and registers the winner into a single output stage.
- Sits between multiple requesters (e.g. CPU data port and DMA/debug masters) and one shared bus or peripheral port on the FPGA build.
- 1-cycle latency, full throughput (one beat per cycle under continuous out_ready).

Parameters:
- WIDTH, 32, data bits per channel.
- NUM_CH, 4, number of input channels; legal range 2..16, need not be a power of 2.
- SEL_W, $clog2(NUM_CH), width of channel index (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel request; bit i belongs to channel i.
- in_data  in  NUM_CH*WIDTH  packed data; channel i occupies [i*WIDTH +: WIDTH].
- in_ready  out  NUM_CH  one-hot-or-zero acceptance, combinational.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered winning data.
- out_sel  out  SEL_W  registered index of the channel that supplied out_data.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset (clk edge with reset=1): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0. in_ready is 0 while reset is high.
- load = !out_valid || out_ready. This is the output stage accepting a new beat.
- Winner is the first i with in_valid[i]=1, scanning ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1 (modulo NUM_CH).
- in_ready[winner] = load; all other in_ready bits are 0. No in_ready bit is set when no channel is valid.
- Transfer on input channel i: in_valid[i] && in_ready[i].
- On a transfer: out_data <= winner data, out_sel <= winner, out_valid <= 1, ptr <= (winner == NUM_CH-1) ? 0 : winner+1.
- load with no valid input: out_valid <= 0; out_data, out_sel and ptr hold.
- !load (out_valid=1, out_ready=0): output registers and ptr hold; every in_ready bit is 0.
- Simultaneous out_ready and new request: the old beat leaves and the new beat loads in the same edge, so there is no bubble.
- ptr advances only on a transfer, never on idle cycles. The just-served channel therefore becomes lowest priority.
- Fairness: with all channels continuously valid, each channel is served exactly once per NUM_CH transfers.
- in_valid may drop without a transfer; no input-side protocol checking.
- Reset mid-operation: a pending out_valid beat is discarded and ptr returns to 0 on the next edge.
- No combinational path from in_valid/in_data to the out_* ports. The only combinational path is in_valid/out_ready to in_ready.

Optional Feature:
- Macro RR_ARB_MUX_LOCK_EN.
- Defined:
  - Adds input port in_last (NUM_CH) and output port out_last (1, registered with the data, reset 0).
  - After a transfer from channel i with in_last[i]=0, the grant is locked to i. Other channels are not granted even if valid.
  - The lock clears on the transfer with in_last[i]=1; ptr then advances to i+1.
  - The lock state register resets to unlocked.
- Not defined: ports are absent and every beat is arbitrated independently.

Decomposition:
- Shared package rr_arb_pkg: function rr_pick(valid, ptr) returning the index plus a found flag, and the constant MAX_CH=16.
- One natural sub-module, rr_arb_pick: purely combinational priority rotate with inputs valid and ptr, outputs grant_idx and any.
- The parent owns all registers.

Test Plan:
- Reset: hold reset 2 cycles with all in_valid=1 -> out_valid=0, out_sel=0, in_ready=0000. First release cycle -> ch0 granted, out_data=ch0 value next cycle.
- Continuous contention: NUM_CH=4, in_valid=1111, out_ready=1, data_i=0x1000+i -> out_sel sequence 0,1,2,3,0,1 and out_data 0x1000..0x1003 repeating, one beat per cycle.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_sel stable and in_ready=0000. Raising out_ready -> next beat loads the same edge, with no idle cycle.
- Sparse and idle: only ch2 valid once with ptr=3 -> winner 2 (wrap), ptr becomes 3. Then idle 5 cycles -> ptr stays 3 and out_valid drops after the beat drains.
- Non-power-of-2: NUM_CH=3, all valid -> sequence 0,1,2,0; out_sel never reaches 3.
- RR_ARB_MUX_LOCK_EN: ch1 sends 3 beats (last on the 3rd) while ch0/ch2 are valid -> out_sel 1,1,1,2,0; out_last=1 only on the 3rd beat.
